// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and key-code outputs of keypad_scanner
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_held;

  modport master (input rows, output cols, output key_out, output key_valid, output key_held);
  modport slave  (output rows, input cols, input key_out, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with debounce; KEYPAD_SCAN_REPEAT_EN adds auto-repeat
// Emits {row one-hot, column one-hot} with a one-cycle key_valid per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);
  localparam int MAX_SD = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAX_P  = (MAX_SD > REPEAT_CYCLES) ? MAX_SD : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_P);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t        state, state_nx;
  logic [3:0]    sync1, sync2, rs;
  logic [1:0]    ci;
  logic [3:0]    cols_q;
  logic [CW-1:0] cnt;
  logic [7:0]    cand, key_out_q;
  logic          key_valid_q, key_held_q;
  logic          rs_onehot, row_on, row_eq, dwell_end, deb_end;
  logic          ci_adv, cand_load, accept, rep_fire;

  assign rs        = ~sync2;
  assign rs_onehot = (rs != 4'd0) && ((rs & (rs - 4'd1)) == 4'd0);
  assign row_on    = |(rs & cand[7:4]);
  assign row_eq    = (rs == cand[7:4]);
  assign dwell_end = (cnt == CW'(SCAN_DIV - 1));
  assign deb_end   = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SCAN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SCAN:     if (dwell_end && rs_onehot) state_nx = PRESS_DB;
      PRESS_DB: if (!row_eq) state_nx = SCAN;
                else if (deb_end) state_nx = HELD;
      HELD:     if (!row_on) state_nx = REL_DB;
      REL_DB:   if (row_on) state_nx = HELD;
                else if (deb_end) state_nx = SCAN;
      default:  state_nx = SCAN;
    endcase
  end

  always_comb begin
    ci_adv    = 1'b0;
    cand_load = 1'b0;
    accept    = 1'b0;
    case (state)
      SCAN: if (dwell_end) begin
        if (rs_onehot) cand_load = 1'b1;
        else           ci_adv    = 1'b1;
      end
      PRESS_DB: if (!row_eq) ci_adv = 1'b1;
                else if (deb_end) accept = 1'b1;
      REL_DB:   if (!row_on && deb_end) ci_adv = 1'b1;
      default: ;
    endcase
  end

`ifdef KEYPAD_SCAN_REPEAT_EN
  logic [CW-1:0] rep_cnt;
  assign rep_fire = (state == HELD) && row_on && (rep_cnt == CW'(REPEAT_CYCLES - 1));

  // Held at zero outside HELD, so both HELD entry and a REL_DB bounce restart the period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        rep_cnt <= '0;
    else if (state != HELD || state_nx != HELD || rep_fire) rep_cnt <= '0;
    else                                               rep_cnt <= rep_cnt + CW'(1);
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1       <= 4'hF;
      sync2       <= 4'hF;
      ci          <= 2'd0;
      cols_q      <= 4'b1110;
      cnt         <= '0;
      cand        <= 8'h00;
      key_out_q   <= 8'h00;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync1 <= kp.rows;
      sync2 <= sync1;
      if (ci_adv) begin
        ci     <= ci + 2'd1;
        cols_q <= ~(4'b0001 << (ci + 2'd1));
      end
      // Every state entry and every dwell wrap restarts the shared counter.
      if (state_nx != state || (state == SCAN && dwell_end)) cnt <= '0;
      else if (state != HELD)                                cnt <= cnt + CW'(1);
      if (cand_load) cand <= {rs, 4'b0001 << ci};
      if (accept)    key_out_q <= cand;
      key_valid_q <= accept | rep_fire;
      key_held_q  <= (state_nx == HELD) || (state_nx == REL_DB);
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_out   = key_out_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a switch-matrix keypad model
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 32;
  // Worst-case press latency plus half a cycle for negedge sampling.
  localparam int LAT_MAX  = 2 + SCAN_DIV * 4 + DEB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pressed = 16'h0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          vcount = 0;
  int          cyc = 0;
  int          vtimes[$];
  logic [7:0]  vcodes[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kif.master)
  );

  always #5 clk = ~clk;

  // Pressed switch (r,c) shorts column c to row r; r=0 is the top row on rows[3].
  function automatic logic [3:0] kp_rows(input logic [3:0] cl, input logic [15:0] p);
    logic [3:0] rw = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (p[r*4+c] && !cl[c]) rw[3-r] = 1'b0;
    return rw;
  endfunction

  assign kif.rows = kp_rows(kif.cols, pressed);

  function automatic logic [15:0] key(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  function automatic logic [7:0] code_of(input int r, input int c);
    logic [3:0] top  = 4'b1000;
    logic [3:0] left = 4'b0001;
    return {top >> r, left << c};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (kif.key_valid) begin
      vcount++;
      vtimes.push_back(cyc);
      vcodes.push_back(kif.key_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int bound, output int lat);
    lat = 0;
    while (lat <= bound) begin
      @(negedge clk);
      lat++;
      if (kif.key_valid) return;
    end
  endtask

  task automatic wait_released(input int bound, output int n);
    n = 0;
    while (n <= bound) begin
      @(negedge clk);
      n++;
      if (!kif.key_held) return;
    end
  endtask

  initial begin
    int lat, n, k, v0, n0, t0, exp_rep, r, c, changes;
    logic [3:0] prev, exp_cols;

    // Reset and free-running scan
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cols", kif.cols, 4'b1110);
    chk("rst_key_out", kif.key_out, 8'h00);
    chk("rst_key_valid", kif.key_valid, 1'b0);
    chk("rst_key_held", kif.key_held, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_cols = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      chk("scan_cols", kif.cols, exp_cols);
    end

    // Clean press of "5"
    v0 = vcount;
    pressed = key(1, 1);
    wait_valid(40, lat);
    chk("p5_latency", 32'(lat <= LAT_MAX), 1);
    chk("p5_code", kif.key_out, 8'b0100_0010);
    cycles(1);
    chk("p5_pulse_width", kif.key_valid, 1'b0);
    chk("p5_held", kif.key_held, 1'b1);
    cycles(20);
    chk("p5_count", vcount - v0, 1);
    pressed = 16'h0;
    cycles(5);
    chk("p5_held_during_rel_db", kif.key_held, 1'b1);
    wait_released(20, n);
    chk("p5_release_time", 32'(n + 5 >= DEB + 2 && n + 5 <= DEB + 4), 1);
    chk("p5_col_after_release", kif.cols, 4'b1011);
    cycles(SCAN_DIV);
    chk("p5_scan_resumes", kif.cols, 4'b0111);

    // Bouncy press of "C", then a short release glitch while held
    v0 = vcount;
    for (int i = 0; i < 3; i++) begin
      pressed = key(0, 3);
      cycles(2);
      pressed = 16'h0;
      cycles(2);
    end
    pressed = key(0, 3);
    wait_valid(60, lat);
    chk("c_found", 32'(lat <= 60), 1);
    chk("c_code", kif.key_out, 8'b1000_1000);
    cycles(1);
    pressed = 16'h0;
    cycles(3);
    pressed = key(0, 3);
    cycles(20);
    chk("c_glitch_held", kif.key_held, 1'b1);
    chk("c_single_pulse", vcount - v0, 1);
    pressed = 16'h0;
    wait_released(20, n);
    chk("c_released", kif.key_held, 1'b0);

    // "1" and "4" together in column 0: ambiguous, scanning continues
    v0 = vcount;
    pressed = key(0, 0) | key(1, 0);
    changes = 0;
    prev = kif.cols;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kif.cols != prev) changes++;
      prev = kif.cols;
    end
    chk("two_keys_no_valid", vcount - v0, 0);
    chk("two_keys_scan_adv", 32'(changes >= 8), 1);
    chk("two_keys_not_held", kif.key_held, 1'b0);
    pressed = key(3, 3);
    wait_valid(40, lat);
    chk("f_latency", 32'(lat <= LAT_MAX), 1);
    chk("f_code", kif.key_out, 8'b0001_1000);
    pressed = 16'h0;
    wait_released(20, n);

    // Reset at debounce count 4 while "0" is pressed
    k = 0;
    while (kif.cols != 4'b0111 && k < 20) begin @(negedge clk); k++; end
    v0 = vcount;
    pressed = key(3, 1);
    k = 0;
    while (kif.cols != 4'b1101 && k < 20) begin @(negedge clk); k++; end
    chk("mdr_col1_reached", 32'(kif.cols == 4'b1101), 1);
    cycles(SCAN_DIV + 4);
    reset = 1'b0;
    #1;
    chk("mdr_cols", kif.cols, 4'b1110);
    chk("mdr_key_out", kif.key_out, 8'h00);
    chk("mdr_key_valid", kif.key_valid, 1'b0);
    chk("mdr_key_held", kif.key_held, 1'b0);
    cycles(3);
    pressed = 16'h0;
    @(posedge clk);
    #1 reset = 1'b1;
    cycles(20);
    chk("mdr_no_valid", vcount - v0, 0);
    chk("mdr_key_out_kept", kif.key_out, 8'h00);

    // Long hold of "A": repeat pulses only when the feature is built in
`ifdef KEYPAD_SCAN_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 0;
`endif
    pressed = key(3, 0);
    wait_valid(40, lat);
    chk("a_latency", 32'(lat <= LAT_MAX), 1);
    chk("a_code", kif.key_out, 8'b0001_0001);
    cycles(1);
    n0 = vtimes.size();
    t0 = vtimes[n0-1];
    cycles(99);
    chk("rep_count", vtimes.size() - n0, exp_rep);
    for (int i = 0; i < vtimes.size() - n0 && i < exp_rep; i++) begin
      chk("rep_spacing", vtimes[n0+i] - t0, REP * (i + 1));
      chk("rep_code", vcodes[n0+i], 8'b0001_0001);
    end
    pressed = 16'h0;
    wait_released(20, n);
    chk("a_released", kif.key_held, 1'b0);

    // Random single-key presses against the code/latency rules
    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      cycles($urandom_range(0, 15));
      v0 = vcount;
      pressed = key(r, c);
      wait_valid(LAT_MAX + 5, lat);
      chk("rnd_latency", 32'(lat <= LAT_MAX), 1);
      chk("rnd_code", kif.key_out, code_of(r, c));
      cycles($urandom_range(10, 25));
      chk("rnd_held", kif.key_held, 1'b1);
      chk("rnd_single_pulse", vcount - v0, 1);
      pressed = 16'h0;
      wait_released(20, n);
      chk("rnd_release_time", 32'(n >= DEB + 2 && n <= DEB + 4), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
